// File: rtl/cordic_gen_freq_pkg.sv
// Shared types, widths and CORDIC constants for the NCO pipeline.
package cordic_gen_freq_pkg;

    localparam int unsigned ITER = 16;
    localparam int unsigned CW   = 20;
    localparam int unsigned PW   = 32;
    localparam int unsigned OW   = 16;

    typedef logic signed [OW-1:0] ws16_t;
    typedef logic signed [CW-1:0] cw_t;
    typedef logic signed [PW-1:0] zw_t;

    // Pre-scaled start vector so the CORDIC gain lands full scale on 32767.
    localparam cw_t KC      = 20'sd19898;
    localparam cw_t OUT_MAX = 20'sd32767;

    // One pipeline slot: rotated vector plus residual angle.
    typedef struct packed {
        cw_t x;
        cw_t y;
        zw_t z;
    } cordic_st_t;

    // atan(2^-i) in units of 2^-32 turn.
    function automatic logic [PW-1:0] atan_lut(input int unsigned i);
        logic [PW-1:0] a;
        a = '0;
        case (i)
            0:       a = 32'h2000_0000;
            1:       a = 32'h12E4_051E;
            2:       a = 32'h09FB_385B;
            3:       a = 32'h0511_11D4;
            4:       a = 32'h028B_0D43;
            5:       a = 32'h0145_D7E1;
            6:       a = 32'h00A2_F61E;
            7:       a = 32'h0051_7C55;
            8:       a = 32'h0028_BE53;
            9:       a = 32'h0014_5F2F;
            10:      a = 32'h000A_2F98;
            11:      a = 32'h0005_17CC;
            12:      a = 32'h0002_8BE6;
            13:      a = 32'h0001_45F3;
            14:      a = 32'h0000_A2FA;
            15:      a = 32'h0000_517D;
            default: a = '0;
        endcase
        return a;
    endfunction

    // Symmetric clamp; -32768 is never produced.
    function automatic ws16_t sat16(input cw_t v);
        ws16_t r;
        if (v > OUT_MAX) begin
            r = 16'sd32767;
        end else if (v < -OUT_MAX) begin
            r = -16'sd32767;
        end else begin
            r = 16'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_gen_freq_step.sv
// Phase accumulator plus 16-stage rotation-mode CORDIC producing cos/sin.
module cordic_gen_freq_step
    import cordic_gen_freq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] step,
    output ws16_t         cos,
    output ws16_t         sin
);

    logic [PW-1:0] phase;
    cordic_st_t    stg   [ITER+1];
    cordic_st_t    nxt_c [ITER+1];

    // Phase accumulator, wraps mod 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else begin
            phase <= phase + step;
        end
    end

    // Quadrant fold into +-90 deg, then one micro-rotation per stage.
    always_comb begin
        cw_t xi;
        cw_t yi;
        zw_t zi;
        xi = '0;
        yi = '0;
        zi = '0;
        for (int i = 0; i <= ITER; i++) begin
            nxt_c[i] = '0;
        end

        if (phase[PW-1] == phase[PW-2]) begin
            nxt_c[0].x = KC;
            nxt_c[0].z = $signed(phase);
        end else begin
            nxt_c[0].x = -KC;
            nxt_c[0].z = $signed(phase ^ 32'h8000_0000);
        end
        nxt_c[0].y = '0;

        for (int i = 0; i < ITER; i++) begin
            xi = stg[i].x;
            yi = stg[i].y;
            zi = stg[i].z;
            if (!zi[PW-1]) begin
                nxt_c[i+1].x = xi - (yi >>> i);
                nxt_c[i+1].y = yi + (xi >>> i);
                nxt_c[i+1].z = zi - $signed(atan_lut(i));
            end else begin
                nxt_c[i+1].x = xi + (yi >>> i);
                nxt_c[i+1].y = yi - (xi >>> i);
                nxt_c[i+1].z = zi + $signed(atan_lut(i));
            end
        end
    end

    // Pipeline registers: slot 0 is the pre-rotation, slots 1..16 the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= ITER; i++) begin
                stg[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= ITER; i++) begin
                stg[i] <= nxt_c[i];
            end
        end
    end

    // Saturating output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos <= '0;
            sin <= '0;
        end else begin
            cos <= sat16(stg[ITER].x);
            sin <= sat16(stg[ITER].y);
        end
    end

endmodule

// File: rtl/cordic_gen_freq.sv
// NCO front end: converts a frequency in Hz to a phase step, then runs the CORDIC core.
module cordic_gen_freq
    import cordic_gen_freq_pkg::*;
#(
    parameter int unsigned FCLK = 100000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] freq,
    output ws16_t         cos,
    output ws16_t         sin
);

    localparam logic [64:0] TWO64 = 65'd1 << 64;
    localparam logic [63:0] K     = 64'(TWO64 / 65'(FCLK));

    logic [PW-1:0] step_r;

    // step = floor(freq * floor(2^64 / FCLK) / 2^32), truncated 96-bit product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r <= '0;
        end else begin
            step_r <= 32'((96'(freq) * 96'(K)) >> 32);
        end
    end

    cordic_gen_freq_step u_core (
        .clk  (clk),
        .rst  (rst),
        .step (step_r),
        .cos  (cos),
        .sin  (sin)
    );

endmodule

// File: tb/tb_cordic_gen_freq.sv
// Directed bench for the frequency-driven NCO and its step-driven core.
module tb_cordic_gen_freq;

    logic               clk;
    logic               rst;
    logic [31:0]        freq;
    logic [31:0]        stp;
    logic signed [15:0] f_cos, f_sin;
    logic signed [15:0] s_cos, s_sin;

    int total = 0;
    int bad   = 0;

    cordic_gen_freq #(.FCLK(100000000)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .freq (freq),
        .cos  (f_cos),
        .sin  (f_sin)
    );

    cordic_gen_freq_step u_step (
        .clk  (clk),
        .rst  (rst),
        .step (stp),
        .cos  (s_cos),
        .sin  (s_sin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] freq;
        logic [31:0] step;
        int          k;
        int          ec;
        int          es;
    } vec_t;

    vec_t vecs [13];

    int sc [100];
    int ss [100];
    int fc [100];
    int fs [100];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        total++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d) at %0t", nm, act, exp, tol, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_cos"}, int'(s_cos), 0, 0);
        chk({tag, "_s_sin"}, int'(s_sin), 0, 0);
        chk({tag, "_f_cos"}, int'(f_cos), 0, 0);
        chk({tag, "_f_sin"}, int'(f_sin), 0, 0);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        repeat (10) tick();
        chk_zero("rst_hold");
    endtask

    // Release reset and check the 18-clock fill, ending on the phase-0 sample.
    task automatic fill_seq(input string tag);
        rst = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            tick();
            chk({tag, "_fill_s_cos"}, int'(s_cos), 0, 0);
            chk({tag, "_fill_s_sin"}, int'(s_sin), 0, 0);
            chk({tag, "_fill_f_cos"}, int'(f_cos), 0, 0);
            chk({tag, "_fill_f_sin"}, int'(f_sin), 0, 0);
        end
        tick();
        chk({tag, "_first_s_cos"}, int'(s_cos), 32767, 8);
        chk({tag, "_first_s_sin"}, int'(s_sin), 0, 8);
        chk({tag, "_first_f_cos"}, int'(f_cos), 32767, 8);
        chk({tag, "_first_f_sin"}, int'(f_sin), 0, 8);
    endtask

    initial begin
        rst  = 1'b1;
        freq = 32'd25000000;
        stp  = 32'h4000_0000;

        vecs[0]  = '{32'd25000000, 32'h4000_0000,  0,  32767,      0};
        vecs[1]  = '{32'd25000000, 32'h4000_0000,  1,      0,  32767};
        vecs[2]  = '{32'd25000000, 32'h4000_0000,  2, -32767,      0};
        vecs[3]  = '{32'd25000000, 32'h4000_0000,  3,      0, -32767};
        vecs[4]  = '{32'd25000000, 32'h4000_0000,  6, -32767,      0};
        vecs[5]  = '{32'd50000000, 32'h8000_0000,  1, -32767,      0};
        vecs[6]  = '{32'd50000000, 32'h8000_0000,  4,  32767,      0};
        vecs[7]  = '{32'd0,        32'h0000_0000, 25,  32767,      0};
        vecs[8]  = '{32'd5000000,  32'h0CCC_CCCC,  1,  31163,  10126};
        vecs[9]  = '{32'd5000000,  32'h0CCC_CCCC,  3,  19260,  26509};
        vecs[10] = '{32'd5000000,  32'h0CCC_CCCC,  5,      0,  32767};
        vecs[11] = '{32'd5000000,  32'h0CCC_CCCC, 12, -26509, -19260};
        vecs[12] = '{32'd5000000,  32'h0CCC_CCCC, 15,      0, -32767};

        // Reset hold, pipeline fill and first sample.
        hold_reset();
        fill_seq("start");

        // Table: sample k of the step core, sample k+1 of the freq wrapper.
        for (int v = 0; v < 13; v++) begin
            rst  = 1'b1;
            freq = vecs[v].freq;
            stp  = vecs[v].step;
            repeat (3) tick();
            rst = 1'b0;
            for (int j = 1; j <= 19 + vecs[v].k; j++) begin
                tick();
                if (j == 18 + vecs[v].k) begin
                    chk($sformatf("vec%0d_s_cos", v), int'(s_cos), vecs[v].ec, 8);
                    chk($sformatf("vec%0d_s_sin", v), int'(s_sin), vecs[v].es, 8);
                end
                if (j == 19 + vecs[v].k) begin
                    chk($sformatf("vec%0d_f_cos", v), int'(f_cos), vecs[v].ec, 8);
                    chk($sformatf("vec%0d_f_sin", v), int'(f_sin), vecs[v].es, 8);
                end
            end
        end

        // 5 MHz stream: wrapper equals core delayed one clock; magnitude, period, quadrature.
        rst  = 1'b1;
        freq = 32'd5000000;
        stp  = 32'h0CCC_CCCC;
        repeat (3) tick();
        rst = 1'b0;
        for (int j = 1; j < 100; j++) begin
            tick();
            sc[j] = int'(s_cos);
            ss[j] = int'(s_sin);
            fc[j] = int'(f_cos);
            fs[j] = int'(f_sin);
        end
        for (int n = 18; n < 58; n++) begin
            longint mag;
            chk($sformatf("delay1_cos_n%0d", n), fc[n+1], sc[n], 0);
            chk($sformatf("delay1_sin_n%0d", n), fs[n+1], ss[n], 0);
            mag = longint'(sc[n]) * sc[n] + longint'(ss[n]) * ss[n];
            chk($sformatf("mag_n%0d", n), int'(mag), 1073676289, 2147352);
        end
        for (int n = 18; n < 38; n++) begin
            chk($sformatf("period_cos_n%0d", n), sc[n+20], sc[n], 2);
            chk($sformatf("period_sin_n%0d", n), ss[n+20], ss[n], 2);
        end
        for (int n = 23; n < 43; n++) begin
            chk($sformatf("lead5_n%0d", n), ss[n], sc[n-5], 16);
        end

        // Asynchronous reset between edges clears outputs at once.
        tick();
        #2 rst = 1'b1;
        #1;
        chk_zero("async_rst");

        // Restart behaves exactly like the first start.
        freq = 32'd25000000;
        stp  = 32'h4000_0000;
        hold_reset();
        fill_seq("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_gen_freq.md
# cordic_gen_freq

Numerically controlled sine/cosine oscillator built on a pipelined CORDIC rotator. A 32-bit phase accumulator advances by a tuning word every clock, and the CORDIC converts the phase into signed 16-bit cos/sin samples. Two top-level variants are provided. `CORDIC_GEN_FREQ` takes a frequency in Hz plus the clock-frequency parameter. `CORDIC_GEN_STEP` takes the raw phase step. Both serve as the LO/test-tone source for DSP datapaths.

## Interface
Parameters (`CORDIC_GEN_FREQ` only):
- FCLK, 100000000, clock frequency in Hz; used to convert `freq` to a phase step.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- freq  in  32  unsigned output frequency in Hz (`CORDIC_GEN_FREQ` only)
- step  in  32  unsigned phase increment, full turn = 2^32 (`CORDIC_GEN_STEP` only)
- cos  out  16  signed cosine sample (`ws16_t`)
- sin  out  16  signed sine sample (`ws16_t`)

One clock; reset is asynchronous and active-high. The clock and reset ports are named `clk` and `rst`.

## Operation
- Phase accumulator: `phase <= phase + step`, 32-bit, wraps mod 2^32; a value of 0 means 0 rad.
- `CORDIC_GEN_FREQ`:
  - Registers `step_r <= (freq * K) >> 32`.
  - K is an elaboration-time constant: K = floor(2^64 / FCLK), 64-bit unsigned.
  - The product is 96-bit and the result is truncated.
  - Example: freq = 5e6 with FCLK = 1e8 gives step 0x0CCCCCCC.
- Pre-rotation (stage 0):
  - If phase[31:30] ∈ {00, 11}: x0 = +KC, y0 = 0, z0 = phase.
  - Otherwise: x0 = −KC, y0 = 0, z0 = phase ^ 0x80000000 (subtracts 180°).
  - KC = 19898, i.e. round(32767 / 1.6467602) to compensate CORDIC gain.
- Rotation stages i = 0..15, rotation mode:
  - d = sign(z).
  - x −= d·(y >>> i), y += d·(x >>> i), z −= d·ATAN[i].
  - ATAN[i] = round(atan(2^−i) / 2π · 2^32).
- Widths: x and y are 20-bit signed internally; z is 32-bit signed.
- Output stage:
  - cos = sat16(x), sin = sat16(y).
  - Saturate to [−32767, +32767]; −32768 is never produced.
- Accuracy: |cos − 32767·cos(θ)| ≤ 8 LSB, same bound for sin.

## Timing
- Throughput: one sample per clock; no handshake; `step`/`freq` are sampled every clock.
- Latency from phase register to outputs: 18 clocks (1 pre-rotation + 16 stages + 1 output register).
- `CORDIC_GEN_FREQ` adds 1 clock for the `step_r` register.
- A new step affects the phase increment on the next edge. Phase continuity is preserved: no phase reset on a step change.
- Reset (asserted at any time, including mid-operation):
  - phase, step_r and all pipeline registers clear to 0 immediately.
  - cos = 0, sin = 0 while reset is held.
- After reset release:
  - Outputs stay 0 until the pipeline fills.
  - The first non-zero sample appears 18 clocks after the first edge with rst = 0, and corresponds to phase 0 (cos ≈ 32767, sin ≈ 0).
- step = 0x80000000: phase alternates 0 / π. step = 0: constant output.

## Structure
- Shared package `types.v`:
  - `ws16_t` macro (signed 16-bit).
  - CORDIC constants: ITER = 16, internal width 20, KC = 19898, and the ATAN table.
- Sub-module `cordic_gen_step` (= `CORDIC_GEN_STEP`) holds the accumulator, CORDIC pipeline and saturation.
- `CORDIC_GEN_FREQ` is a thin wrapper: the freq→step register plus one instance of `CORDIC_GEN_STEP`.
- Optional: a generate loop for the 16 stages.

## Test plan
- Reset held 10 clocks → cos = sin = 0. After release, outputs stay 0 for 18 clocks, then cos = 32767±8, sin = 0±8.
- step = 0x40000000 → repeating (32767, 0), (0, 32767), (−32767, 0), (0, −32767), each within ±8.
- step = 0x0CCCCCCC → period 20 samples; cos² + sin² within ±0.2% of 32767²; sin leads zero crossings of cos by 5 samples.
- `CORDIC_GEN_FREQ` (FCLK = 1e8, freq = 5e6) vs `CORDIC_GEN_STEP` (step = 0x0CCCCCCC) → identical sample streams, with the FREQ variant delayed exactly 1 clock.
- step = 0x80000000 → cos alternates +32767 / −32767, sin = 0±8; step = 0 → constant (32767, 0).
- Reset asserted mid-run asynchronously (between edges) → outputs 0 immediately; restart sequence identical to the first test.
